serial_addsub: RTL and testbench

//  Parametrised bit-serial adder/subtractor, LSB first, one bit per clock.

---
 rtl/serial_addsub_pkg.sv | 19 +
 rtl/serial_addsub_fa_cell.sv | 14 +
 rtl/serial_addsub.sv | 108 ++++++++++
 tb/tb_serial_addsub.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Holds the FSM state encoding, the default operand width and a counter-width helper.
package serial_addsub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Encoding 2'd3 is never entered; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Single-bit full adder reused every cycle by the serial datapath.
// Purely combinational.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic ca
);

    assign sum = a ^ b ^ cin;
    assign ca  = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single fa_cell.
// Result valid with a one-cycle done pulse WIDTH+1 cycles after the start cycle.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;
    logic             fa_s;
    logic             fa_ca;

    fa_cell u_fa (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .cin (carry_q),
        .sum (fa_s),
        .ca  (fa_ca)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    sum_q   <= sum_d;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= fa_ca;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        // carry_q here is the carry into the MSB
                        cout_q  <= fa_ca;
                        ovf_q   <= carry_q ^ fa_ca;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub at WIDTH 1, 8 and 16 against an arithmetic reference.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start1 = 0, sub1 = 0, cin1 = 0;
    logic [0:0]  a1 = '0, b1 = '0, sum1;
    logic        busy1, done1, cout1, ovf1;

    logic        start8 = 0, sub8 = 0, cin8 = 0;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic        busy8, done8, cout8, ovf8;

    logic        start16 = 0, sub16 = 0, cin16 = 0;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        busy16, done16, cout16, ovf16;

    serial_addsub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

    serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic with a signed range test for overflow.
    task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb,
                         output logic [15:0] s, output logic co, output logic ov);
        longint m, ua, ub, tot, sa, sbv, st, half;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(av) & m;
        ub   = longint'(bv) & m;
        tot  = sb ? (ua + ((~ub) & m) + 1) : (ua + ub + longint'(ci));
        s    = 16'(tot & m);
        co   = ((tot >> w) & 1) != 0;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sbv  = (ub >= half) ? ub - (m + 1) : ub;
        st   = sb ? (sa - sbv) : (sa + sbv + longint'(ci));
        ov   = (st < -half) || (st > half - 1);
    endtask

    task automatic drive(input int w, input logic st, input logic [15:0] av,
                         input logic [15:0] bv, input logic ci, input logic sb);
        case (w)
            1: begin start1 = st; a1 = av[0:0]; b1 = bv[0:0]; cin1 = ci; sub1 = sb; end
            8: begin start8 = st; a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci; sub8 = sb; end
            default: begin start16 = st; a16 = av; b16 = bv; cin16 = ci; sub16 = sb; end
        endcase
    endtask

    task automatic peek(input int w, output logic bz, output logic dn,
                        output logic [15:0] s, output logic co, output logic ov);
        case (w)
            1: begin bz = busy1; dn = done1; s = {15'd0, sum1}; co = cout1; ov = ovf1; end
            8: begin bz = busy8; dn = done8; s = {8'd0, sum8}; co = cout8; ov = ovf8; end
            default: begin bz = busy16; dn = done16; s = sum16; co = cout16; ov = ovf16; end
        endcase
    endtask

    // One full operation; operands are scrambled right after acceptance.
    task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic sb, input string tag);
        logic [15:0] es, s;
        logic ec, eo, bz, dn, co, ov;
        int lat;
        model(w, av, bv, ci, sb, es, ec, eo);
        drive(w, 1'b1, av, bv, ci, sb);
        @(posedge clk); #1;
        drive(w, 1'b0, ~av, ~bv, ~ci, ~sb);
        lat = 1;
        peek(w, bz, dn, s, co, ov);
        while (!dn && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            peek(w, bz, dn, s, co, ov);
        end
        chk({tag, ".lat"}, 64'(lat), 64'(w + 1));
        chk({tag, ".busy"}, 64'(bz), 64'(1));
        chk({tag, ".sum"}, 64'(s), 64'(es));
        chk({tag, ".cout"}, 64'(co), 64'(ec));
        chk({tag, ".ovf"}, 64'(ov), 64'(eo));
        @(posedge clk); #1;
        peek(w, bz, dn, s, co, ov);
        chk({tag, ".done_drop"}, 64'(dn), 64'(0));
        chk({tag, ".idle"}, 64'(bz), 64'(0));
        chk({tag, ".hold"}, 64'(s), 64'(es));
    endtask

    initial begin
        int lat, ndone, dcyc, first, second;
        logic [7:0] got_sum;
        logic got_cout, got_ovf;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 64'(busy8), 64'(0));
        chk("rst.done", 64'(done8), 64'(0));
        chk("rst.sum", 64'(sum8), 64'(0));
        chk("rst.cout", 64'(cout8), 64'(0));
        chk("rst.ovf", 64'(ovf8), 64'(0));
        chk("rst.sum16", 64'(sum16), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed WIDTH=8 cases
        run_op(8, 16'h0F, 16'h01, 1'b0, 1'b0, "add_0f_01");
        run_op(8, 16'hFF, 16'h01, 1'b0, 1'b0, "add_ff_01");
        run_op(8, 16'h7F, 16'h01, 1'b0, 1'b0, "add_7f_01");
        run_op(8, 16'h05, 16'h07, 1'b0, 1'b1, "sub_05_07");
        run_op(8, 16'h80, 16'h01, 1'b0, 1'b1, "sub_80_01");
        run_op(8, 16'hA5, 16'h3C, 1'b1, 1'b0, "add_cin");
        run_op(8, 16'h00, 16'h00, 1'b1, 1'b1, "sub_cin_ignored");

        // start re-pulsed at cycles 3 and 9 of an op
        drive(8, 1'b1, 16'h21, 16'h13, 1'b0, 1'b0);
        @(posedge clk); #1;
        lat = 1; ndone = 0; dcyc = 0;
        got_sum = '0; got_cout = 1'b0; got_ovf = 1'b0;
        while (lat < 16) begin
            if (lat == 3 || lat == 9) drive(8, 1'b1, 16'hAA, 16'h55, 1'b1, 1'b1);
            else                      drive(8, 1'b0, 16'h00, 16'h00, 1'b0, 1'b0);
            @(posedge clk); #1;
            lat++;
            if (done8) begin
                ndone++; dcyc = lat;
                got_sum = sum8; got_cout = cout8; got_ovf = ovf8;
            end
        end
        chk("repulse.ndone", 64'(ndone), 64'(1));
        chk("repulse.lat", 64'(dcyc), 64'(9));
        chk("repulse.sum", 64'(got_sum), 64'(8'h34));
        chk("repulse.cout", 64'(got_cout), 64'(0));
        chk("repulse.ovf", 64'(got_ovf), 64'(0));
        chk("repulse.idle", 64'(busy8), 64'(0));

        // Reset during RUN cycle 4 aborts the op
        drive(8, 1'b1, 16'hF0, 16'h0F, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(8, 1'b0, 16'h00, 16'h00, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort.busy", 64'(busy8), 64'(0));
        chk("abort.sum", 64'(sum8), 64'(0));
        chk("abort.done", 64'(done8), 64'(0));
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        chk("abort.no_done", 64'(ndone), 64'(0));
        run_op(8, 16'h12, 16'h34, 1'b0, 1'b0, "after_abort");

        // start held high: one op every WIDTH+2 cycles
        drive(8, 1'b1, 16'h03, 16'h04, 1'b0, 1'b0);
        lat = 0; first = -1; second = -1;
        while (lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (done8) begin
                if (first < 0) first = lat;
                else if (second < 0) second = lat;
            end
        end
        drive(8, 1'b0, 16'h00, 16'h00, 1'b0, 1'b0);
        chk("hold.first", 64'(first), 64'(9));
        chk("hold.period", 64'(second - first), 64'(10));
        chk("hold.sum", 64'(sum8), 64'(8'h07));
        repeat (12) @(posedge clk);
        #1;

        // WIDTH=1: full-adder truth table, then subtract
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run_op(1, {15'd0, v[2]}, {15'd0, v[1]}, v[0], 1'b0, $sformatf("w1_add%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v;
            v = 2'(i);
            run_op(1, {15'd0, v[1]}, {15'd0, v[0]}, 1'b0, 1'b1, $sformatf("w1_sub%0d", i));
        end

        // Random sweeps
        for (int i = 0; i < 12; i++)
            run_op(8, 16'($urandom), 16'($urandom), 1'($urandom_range(1)),
                   1'($urandom_range(1)), $sformatf("w8_rnd%0d", i));
        run_op(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "w16_wrap");
        run_op(16, 16'h8000, 16'h0001, 1'b0, 1'b1, "w16_subovf");
        for (int i = 0; i < 30; i++)
            run_op(16, 16'($urandom), 16'($urandom), 1'($urandom_range(1)),
                   1'($urandom_range(1)), $sformatf("w16_rnd%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
